// File: rtl/seg7_mux_decoder.sv
// Decodes a two-digit multiplexed 7-segment bus {an, seg} back to BCD digits
// and a binary 0-99 value, with settle filtering and stall detection.
module seg7_mux_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mux_in,
    output logic [6:0] value_o,
    output logic [3:0] uni_o,
    output logic [3:0] dec_o,
    output logic       valid_o,
    output logic       update_o,
    output logic       err_o,
    output logic       stall_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic {
        WAIT_UNI,
        WAIT_DEC
    } state_t;

    state_t state_q, state_d;

    logic [7:0] meta_q, sync_q, prev_q;
    logic [7:0] stab_q, stab_d;
    logic [TW-1:0] tout_q, tout_d;
    logic armed_q;
    logic an_edge, capture, stall_hit;
    logic [3:0] cap_digit;
    logic cap_bad;
    logic [3:0] held_uni_q;
    logic held_bad_q;
    logic store_uni, commit;
    logic [6:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= mux_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        an_edge = sync_q[7] ^ prev_q[7];
        stab_d = stab_q;
        if (sync_q != prev_q)
            stab_d = '0;
        else if (stab_q != SETTLE)
            stab_d = stab_q + 8'd1;
        tout_d = tout_q;
        if (an_edge)
            tout_d = '0;
        else if (tout_q != TMAX)
            tout_d = tout_q + 1'b1;
        stall_hit = (tout_d == TMAX);
        // One strobe per phase: the edge where the count first saturates
        capture = armed_q && (stab_d == SETTLE) && (stab_q != SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q  <= '0;
            tout_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            stab_q <= stab_d;
            tout_q <= tout_d;
            if (an_edge)
                armed_q <= 1'b1;
            else if (capture)
                armed_q <= 1'b0;
        end
    end

    always_comb begin
        cap_digit = 4'hF;
        cap_bad   = 1'b0;
        unique case (sync_q[6:0])
            7'b1000000: cap_digit = 4'd0;
            7'b1111001: cap_digit = 4'd1;
            7'b0100100: cap_digit = 4'd2;
            7'b0110000: cap_digit = 4'd3;
            7'b0011001: cap_digit = 4'd4;
            7'b0010010: cap_digit = 4'd5;
            7'b0000010: cap_digit = 4'd6;
            7'b1111000: cap_digit = 4'd7;
            7'b0000000: cap_digit = 4'd8;
            7'b0010000: cap_digit = 4'd9;
            default:    cap_bad   = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        store_uni = 1'b0;
        commit    = 1'b0;
        if (stall_hit) begin
            state_d = WAIT_UNI;
        end else if (capture) begin
            unique case (state_q)
                WAIT_UNI: begin
                    if (!sync_q[7]) begin
                        store_uni = 1'b1;
                        state_d   = WAIT_DEC;
                    end
                end
                WAIT_DEC: begin
                    if (sync_q[7]) begin
                        commit  = 1'b1;
                        state_d = WAIT_UNI;
                    end else begin
                        store_uni = 1'b1;
                    end
                end
                default: state_d = WAIT_UNI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= WAIT_UNI;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_uni_q <= '0;
            held_bad_q <= 1'b0;
        end else if (stall_hit) begin
            held_uni_q <= '0;
            held_bad_q <= 1'b0;
        end else if (store_uni) begin
            held_uni_q <= cap_digit;
            held_bad_q <= cap_bad;
        end
    end

    assign sum = ({3'b000, cap_digit} << 3)
               + ({3'b000, cap_digit} << 1)
               + {3'b000, held_uni_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_o  <= '0;
            uni_o    <= '0;
            dec_o    <= '0;
            valid_o  <= 1'b0;
            update_o <= 1'b0;
            err_o    <= 1'b0;
            stall_o  <= 1'b0;
        end else begin
            update_o <= 1'b0;
            err_o    <= 1'b0;
            stall_o  <= stall_hit;
            if (stall_hit) begin
                valid_o <= 1'b0;
            end else if (commit) begin
                if (!held_bad_q && !cap_bad) begin
                    value_o  <= sum;
                    uni_o    <= held_uni_q;
                    dec_o    <= cap_digit;
                    valid_o  <= 1'b1;
                    update_o <= !valid_o || (sum != value_o);
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder with a behavioural
// counter/display driver for the loopback section.
module tb_seg7_mux_decoder;

    localparam int S = 4;
    localparam int T = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mux_in = 8'hFF;
    logic [6:0] value_o;
    logic [3:0] uni_o, dec_o;
    logic       valid_o, update_o, err_o, stall_o;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    logic       lb_en = 1'b0;
    logic [10:0] rc = '0;
    int lb_cnt = 95;
    int lb_prev = 0;
    bit lb_have = 0;
    bit saw_wrap = 0;
    int lb_n = 0;

    seg7_mux_decoder #(
        .SETTLE_CYCLES(S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mux_in(mux_in),
        .value_o(value_o),
        .uni_o(uni_o),
        .dec_o(dec_o),
        .valid_o(valid_o),
        .update_o(update_o),
        .err_o(err_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic phase(input logic an, input logic [6:0] seg, input int n);
        mux_in = {an, seg};
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int u, input int d, input int n);
        phase(1'b0, seg_of(u), n);
        phase(1'b1, seg_of(d), n);
    endtask

    always @(negedge clk) begin
        if (update_o) upd_cnt++;
        if (err_o) err_cnt++;
    end

    always @(negedge clk) begin
        if (lb_en) begin
            rc = rc + 11'd1;
            if (rc == 11'd0)
                lb_cnt = (lb_cnt == 99) ? 0 : lb_cnt + 1;
            mux_in = rc[10] ? {1'b1, seg_of(lb_cnt / 10)}
                            : {1'b0, seg_of(lb_cnt % 10)};
        end
    end

    always @(negedge clk) begin
        if (lb_en && update_o) begin
            if (lb_have) begin
                check("lb_inc", int'(value_o), (lb_prev + 1) % 100);
                if (lb_prev == 99 && value_o == 7'd0) saw_wrap = 1;
            end
            lb_prev = int'(value_o);
            lb_have = 1;
            lb_n++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, e0, lat;
        repeat (3) @(negedge clk);
        check("rst_value", int'(value_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_stall", int'(stall_o), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: 47 with latency measurement
        u0 = upd_cnt;
        phase(1'b0, seg_of(7), 1024);
        mux_in = {1'b1, seg_of(4)};
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (update_o && lat == 0) lat = i;
        end
        repeat (980) @(negedge clk);
        check("t1_value", int'(value_o), 47);
        check("t1_uni", int'(uni_o), 7);
        check("t1_dec", int'(dec_o), 4);
        check("t1_valid", int'(valid_o), 1);
        check("t1_latency", lat, S + 3);
        check("t1_updates", upd_cnt - u0, 1);

        // 2: repeats produce no update, a change produces one
        u0 = upd_cnt;
        for (int k = 0; k < 5; k++) frame(7, 4, 20);
        check("t2_value_hold", int'(value_o), 47);
        check("t2_no_update", upd_cnt - u0, 0);
        frame(8, 4, 20);
        check("t2_value_48", int'(value_o), 48);
        check("t2_one_update", upd_cnt - u0, 1);

        // 3: invalid tens pattern
        e0 = err_cnt;
        u0 = upd_cnt;
        phase(1'b0, seg_of(3), 20);
        phase(1'b1, 7'b1111111, 20);
        check("t3_err", err_cnt - e0, 1);
        check("t3_value_hold", int'(value_o), 48);
        check("t3_valid_hold", int'(valid_o), 1);
        frame(5, 0, 20);
        check("t3_value_5", int'(value_o), 5);
        check("t3_dec_0", int'(dec_o), 0);
        check("t3_update", upd_cnt - u0, 1);

        // 4: glitches inside a units phase, short an toggle
        u0 = upd_cnt;
        phase(1'b0, seg_of(2), 2);
        phase(1'b0, 7'b0000000, 2);
        phase(1'b0, seg_of(2), 20);
        phase(1'b0, 7'b0000000, 2);
        phase(1'b0, seg_of(2), 10);
        phase(1'b1, seg_of(6), 20);
        check("t4_glitch_value", int'(value_o), 62);
        check("t4_glitch_uni", int'(uni_o), 2);
        phase(1'b0, seg_of(1), 20);
        phase(1'b1, seg_of(9), 2);
        phase(1'b0, seg_of(1), 20);
        check("t4_short_an", int'(value_o), 62);
        phase(1'b1, seg_of(9), 20);
        check("t4_value_91", int'(value_o), 91);
        check("t4_updates", upd_cnt - u0, 2);

        // 5: stall and recovery
        u0 = upd_cnt;
        repeat (4000) @(negedge clk);
        check("t5_pre_stall", int'(stall_o), 0);
        check("t5_pre_valid", int'(valid_o), 1);
        repeat (200) @(negedge clk);
        check("t5_stall", int'(stall_o), 1);
        check("t5_valid_low", int'(valid_o), 0);
        check("t5_value_hold", int'(value_o), 91);
        phase(1'b0, seg_of(2), 20);
        check("t5_stall_clear", int'(stall_o), 0);
        phase(1'b1, seg_of(1), 20);
        check("t5_value_12", int'(value_o), 12);
        check("t5_valid", int'(valid_o), 1);
        check("t5_update", upd_cnt - u0, 1);

        // 6: loopback with reset mid-frame
        e0 = err_cnt;
        lb_en = 1'b1;
        repeat (3 * 2048 + 500) @(negedge clk);
        rst_n = 1'b0;
        lb_have = 0;
        repeat (3) @(negedge clk);
        check("t6_rst_value", int'(value_o), 0);
        check("t6_rst_uni", int'(uni_o), 0);
        check("t6_rst_valid", int'(valid_o), 0);
        rst_n = 1'b1;
        lb_n = 0;
        repeat (7 * 2048) @(negedge clk);
        lb_en = 1'b0;
        check("t6_no_err", err_cnt - e0, 0);
        check("t6_wrap", int'(saw_wrap), 1);
        check("t6_updates_seen", int'(lb_n >= 4), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
